// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types, palette constants and sizing helper for the framebuffer
package fb_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t PAL_BLACK = 16'h0000;
  localparam rgb565_t PAL_WHITE = 16'hFFFF;

  function automatic int pix_w_calc(input int n_pix);
    return (n_pix <= 1) ? 1 : $clog2(n_pix);
  endfunction

endpackage

// File: rtl/fb_palette.sv
// rtl/fb_palette.sv - register-file palette, one write port, one registered read port
module fb_palette
  import fb_pkg::*;
#(
  parameter int BPP = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [BPP-1:0] wr_addr,
  input  rgb565_t        wr_data,
  input  logic           rd_en,
  input  logic [BPP-1:0] rd_addr,
  output rgb565_t        rd_data
);

  localparam int N_ENT = 1 << BPP;

  rgb565_t pal [N_ENT];

  // Entry 0 black, the rest white, so a 1-bpp plane looks like the legacy mono framebuffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) begin
        pal[i] <= (i == 0) ? PAL_BLACK : PAL_WHITE;
      end
      rd_data <= PAL_BLACK;
    end else begin
      if (wr_en) pal[wr_addr] <= wr_data;
      if (rd_en) rd_data <= pal[rd_addr];
    end
  end

endmodule

// File: rtl/fb_pixel_source.sv
// rtl/fb_pixel_source.sv - paletted, optionally double-buffered framebuffer streaming RGB565 to the TFT driver
module fb_pixel_source
  import fb_pkg::*;
#(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int BPP        = 1,
  parameter int DOUBLE_BUF = 1,
  localparam int PIX_W     = pix_w_calc(H_RES * V_RES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_addr,
  input  logic [BPP-1:0]   wr_data,
  input  logic             pal_wr_en,
  input  logic [BPP-1:0]   pal_addr,
  input  logic [15:0]      pal_data,
  input  logic             swap_req,
  output logic             swap_pending,
  input  logic             pix_next,
  output logic [15:0]      pix_data,
  output logic             pix_valid,
  output logic             frame_start,
  output logic             front_sel
);

  localparam int               N_PIX = H_RES * V_RES;
  localparam logic [PIX_W-1:0] LAST  = PIX_W'(N_PIX - 1);
  localparam logic             DB    = (DOUBLE_BUF != 0);

  logic [PIX_W-1:0] idx;
  logic [PIX_W-1:0] idx_nxt;
  logic             started;
  logic             s1_fresh;
  logic             accept;
  logic             wrap;
  logic             do_swap;
  logic             front_nxt;
  logic             s1_load;
  logic [BPP-1:0]   ram_q;

  // Plane bit on top of the pixel index; the upper half stays unused when single-buffered.
  logic [BPP-1:0] ram [0:(2 << PIX_W) - 1];

  always_comb begin
    accept    = pix_next & pix_valid;
    wrap      = accept & (idx == LAST);
    do_swap   = wrap & swap_pending;
    front_nxt = front_sel ^ do_swap;
    idx_nxt   = idx;
    if (wrap)        idx_nxt = '0;
    else if (accept) idx_nxt = idx + PIX_W'(1);
    s1_load   = accept | ~started;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      started      <= 1'b0;
      s1_fresh     <= 1'b0;
      pix_valid    <= 1'b0;
      frame_start  <= 1'b0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      idx          <= idx_nxt;
      started      <= 1'b1;
      s1_fresh     <= s1_load;
      frame_start  <= wrap;
      front_sel    <= front_nxt;
      swap_pending <= DB & ((swap_pending & ~do_swap) | swap_req);
      if (accept)        pix_valid <= 1'b0;
      else if (s1_fresh) pix_valid <= 1'b1;
    end
  end

  // Stage 1 addresses with next-state index/plane so pixel 0 after a swap comes from the new front.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr <= LAST)) ram[{~front_sel & DB, wr_addr}] <= wr_data;
    if (s1_load) ram_q <= ram[{front_nxt, idx_nxt}];
  end

  fb_palette #(
    .BPP (BPP)
  ) u_palette (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pal_wr_en),
    .wr_addr (pal_addr),
    .wr_data (pal_data),
    .rd_en   (s1_fresh),
    .rd_addr (ram_q),
    .rd_data (pix_data)
  );

endmodule

// File: tb/tb_fb_pixel_source.sv
// tb/tb_fb_pixel_source.sv - scoreboard bench for fb_pixel_source on a 10x10, 4-bpp, double-buffered instance
module tb_fb_pixel_source;
  import fb_pkg::*;

  localparam int H    = 10;
  localparam int V    = 10;
  localparam int NPIX = H * V;
  localparam int BPP  = 4;
  localparam int PW   = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          pal_wr_en;
  logic [3:0]    pal_addr;
  logic [15:0]   pal_data;
  logic          swap_req;
  logic          swap_pending;
  logic          pix_next;
  logic [15:0]   pix_data;
  logic          pix_valid;
  logic          frame_start;
  logic          front_sel;

  always #5 clk = ~clk;

  fb_pixel_source #(
    .H_RES      (H),
    .V_RES      (V),
    .BPP        (BPP),
    .DOUBLE_BUF (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pal_wr_en    (pal_wr_en),
    .pal_addr     (pal_addr),
    .pal_data     (pal_data),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .pix_next     (pix_next),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .frame_start  (frame_start),
    .front_sel    (front_sel)
  );

  int          tests = 0;
  int          fails = 0;
  logic [16:0] exp_q [$];
  logic [3:0]  mem_m [2][NPIX];
  bit          known_m [2][NPIX];
  logic [15:0] pal_m [16];
  int          m_idx;
  bit          m_front;
  bit          m_pend;
  bit          pv_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_idx   = 0;
    m_front = 1'b0;
    m_pend  = 1'b0;
    for (int i = 0; i < 16; i++) pal_m[i] = (i == 0) ? 16'h0000 : 16'hFFFF;
  endtask

  // Bit 16 marks a pixel whose plane content was never written: skipped by the monitor.
  function automatic logic [16:0] exp_pix();
    if (!known_m[m_front][m_idx]) return 17'h10000;
    return {1'b0, pal_m[mem_m[m_front][m_idx]]};
  endfunction

  task automatic wr_px(input int a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = PW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < NPIX) begin
      mem_m[m_front ? 0 : 1][a]   = d;
      known_m[m_front ? 0 : 1][a] = 1'b1;
    end
  endtask

  task automatic wr_pal(input logic [3:0] a, input logic [15:0] d);
    pal_wr_en = 1'b1;
    pal_addr  = a;
    pal_data  = d;
    tick();
    pal_wr_en = 1'b0;
    pal_m[a]  = d;
  endtask

  task automatic swap_pulse();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    m_pend   = 1'b1;
    @(negedge clk);
    chk("swap_pending_set", 32'(swap_pending), 32'(m_pend));
    tick();
  endtask

  // One pixel advance at 4-cycle spacing; optional swap_req, stray pix_next and palette write.
  task automatic step(input bit sreq, input bit dbl, input bit pw, input logic [3:0] pa,
                      input logic [15:0] pd);
    bit wrap;
    bit dosw;
    pix_next = 1'b1;
    swap_req = sreq;
    wrap     = (m_idx == NPIX - 1);
    m_idx    = wrap ? 0 : m_idx + 1;
    dosw     = wrap && m_pend;
    m_front  = m_front ^ dosw;
    m_pend   = (m_pend && !dosw) || sreq;
    exp_q.push_back(exp_pix());
    tick();
    pix_next  = dbl;
    swap_req  = 1'b0;
    pal_wr_en = pw;
    pal_addr  = pa;
    pal_data  = pd;
    @(negedge clk);
    chk("valid_drop", 32'(pix_valid), 32'(0));
    chk("frame_start", 32'(frame_start), 32'(wrap));
    chk("front_sel", 32'(front_sel), 32'(m_front));
    chk("swap_pending", 32'(swap_pending), 32'(m_pend));
    tick();
    pix_next  = 1'b0;
    pal_wr_en = 1'b0;
    if (pw) pal_m[pa] = pd;
    @(negedge clk);
    chk("valid_rise", 32'(pix_valid), 32'(1));
    chk("frame_start_off", 32'(frame_start), 32'(0));
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    if (pix_valid && !pv_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pix_unexpected: got %h expected none", pix_data);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if (!e[16]) chk("pix_data", 32'(pix_data), 32'(e[15:0]));
      end
    end
    pv_prev = pix_valid;
  end

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    pal_wr_en = 1'b0;
    pal_addr  = '0;
    pal_data  = '0;
    swap_req  = 1'b0;
    pix_next  = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < NPIX; a++) known_m[p][a] = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_valid", 32'(pix_valid), 32'(0));
    chk("rst_pix_data", 32'(pix_data), 32'(16'h0000));
    chk("rst_frame_start", 32'(frame_start), 32'(0));
    chk("rst_swap_pending", 32'(swap_pending), 32'(0));
    chk("rst_front_sel", 32'(front_sel), 32'(0));
    tick();
    rst_n = 1'b1;
    exp_q.push_back(exp_pix());
    repeat (3) tick();

    // Plane 1: pixels 0 and 2 use entry 1 (white), the rest entry 0.
    for (int a = 0; a < NPIX; a++) wr_px(a, (a == 0 || a == 2) ? 4'd1 : 4'd0);
    swap_pulse();
    for (int i = 0; i < NPIX; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    for (int a = 0; a < NPIX; a++) wr_px(a, 4'd0);
    swap_pulse();

    // Asynchronous reset mid-frame with a swap pending and plane 1 in front.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pix_valid", 32'(pix_valid), 32'(0));
    chk("arst_pix_data", 32'(pix_data), 32'(16'h0000));
    chk("arst_swap_pending", 32'(swap_pending), 32'(0));
    chk("arst_front_sel", 32'(front_sel), 32'(0));
    chk("arst_frame_start", 32'(frame_start), 32'(0));
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    exp_q.push_back(exp_pix());
    @(negedge clk);
    chk("valid_c0", 32'(pix_valid), 32'(0));
    tick();
    @(negedge clk);
    chk("valid_c1", 32'(pix_valid), 32'(0));
    tick();
    @(negedge clk);
    chk("valid_c2", 32'(pix_valid), 32'(1));
    tick();
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);

    // Multi-bit palette indices on the back plane, plus an out-of-range write.
    wr_pal(4'd3, 16'hF800);
    wr_pal(4'd4, 16'h07E0);
    wr_pal(4'd6, 16'h001F);
    wr_px(4, 4'd4);
    wr_px(5, 4'd3);
    wr_px(6, 4'd6);
    wr_px(NPIX, 4'd5);
    swap_pulse();
    while (m_idx != 0) step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);

    // Palette write coinciding with the lookup of pixel 7 (entry 0).
    step(1'b0, 1'b0, 1'b1, 4'd0, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);

    // swap_req on the wrap cycle only takes effect at the following wrap.
    while (m_idx != NPIX - 1) step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < NPIX + 2; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);

    repeat (4) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_pixel_source.md
Name: fb_pixel_source

Overview:
- Parametrised framebuffer and pixel streamer that feeds RGB565 pixels to tft_ili9341 through its pixel-data/next-pixel interface.
- Successor to the fixed 1-bit, read-only framebuffer.
- Adds configurable bits-per-pixel, a writable palette, a host write port and optional double buffering with a frame-synchronous swap.
- Sits between the SoC/host logic (writer) and the TFT driver (reader), in the single tft_clk domain.

Parameters:
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- BPP, 1, bits per pixel; legal values are 1, 2, 4 and 8. The palette has 2^BPP entries.
- DOUBLE_BUF, 1, 1 = two pixel planes with front/back swap; 0 = a single plane.
- PIX_W, derived, $clog2(H_RES*V_RES).

Ports:
- clk  in  1  sole clock (tft_clk domain).
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  pixel write strobe, back plane.
- wr_addr  in  PIX_W  linear pixel index, y*H_RES+x.
- wr_data  in  BPP  pixel palette index.
- pal_wr_en  in  1  palette write strobe.
- pal_addr  in  BPP  palette entry.
- pal_data  in  16  RGB565 value.
- swap_req  in  1  pulse: request a front/back swap at the next frame boundary.
- swap_pending  out  1  high from swap_req until the swap is applied.
- pix_next  in  1  one-cycle strobe from the TFT driver: current pixel consumed.
- pix_data  out  16  RGB565 of the current pixel.
- pix_valid  out  1  pix_data is valid for the current index.
- frame_start  out  1  one-cycle pulse when the read index wraps to 0.
- front_sel  out  1  plane currently displayed; always 0 when DOUBLE_BUF=0.

Behaviour:
- Reset values: read index 0, front_sel 0, swap_pending 0, frame_start 0, pix_valid 0, pix_data 16'h0000.
  - Palette resets to entry 0 = 16'h0000 and all other entries = 16'hFFFF, so 1-bpp output matches legacy black/white.
  - Pixel RAM contents are not reset.
- Read pipeline:
  - Stage 1: RAM read at {front_sel, index}.
  - Stage 2: palette lookup, registered into pix_data.
  - After reset deassertion, pix_valid rises 2 cycles later with pixel 0.
- On pix_next:
  - Index increments; it wraps to 0 after H_RES*V_RES-1.
  - pix_valid drops the next cycle.
  - The new pix_data and pix_valid=1 appear exactly 2 cycles after the pix_next cycle.
  - pix_next while pix_valid=0 is ignored; no index advance. The driver must space strobes at least 3 cycles apart.
- Wrap:
  - The cycle the index becomes 0, frame_start pulses for one cycle.
  - If swap_pending is set in that same cycle, front_sel toggles and swap_pending clears.
  - The read of pixel 0 uses the new front_sel.
- swap_req:
  - Sets swap_pending the next cycle. Repeated requests while pending coalesce.
  - swap_req coincident with the wrap cycle is not applied until the following wrap.
  - With DOUBLE_BUF=0, swap_req is ignored and swap_pending stays 0.
- Writes:
  - wr_en writes wr_data to plane {~front_sel, wr_addr}, or to the single plane when DOUBLE_BUF=0.
  - Writes become visible after a swap. In single-plane mode they are visible immediately: tearing is allowed.
  - wr_addr >= H_RES*V_RES: the write is dropped.
  - A write in the same cycle as a swap targets the plane that is back before the toggle.
- Palette:
  - pal_wr_en updates the entry at the clock edge.
  - A stage-2 lookup of the same entry in that cycle returns the old value.
  - New values apply to subsequent pixels; there is no frame sync.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous); the stream restarts at pixel 0 on plane 0.

Decomposition:
- Package fb_pkg holds:
  - RGB565 typedef;
  - constants PAL_BLACK = 16'h0000 and PAL_WHITE = 16'hFFFF;
  - a function computing PIX_W.
- One sub-module, fb_palette: register-file palette with reset defaults, one write port and one registered read port. The RAM is inferred inline in fb_pixel_source.

Test Plan:
- Reset, then 1-bpp default contents written to 0 -> pix_valid at cycle 2 after rst_n rises; pix_data=16'h0000. After one pix_next, pix_data=16'h0000 again at +2 cycles.
- BPP=4: write pal[3]=16'hF800 and pixel 5=3; swap; stream -> pixel 5 outputs 16'hF800; pixels 4 and 6 output the palette of their own index.
- Wrap: issue 76800 pix_next strobes at 4-cycle spacing -> frame_start pulses once, exactly when the index returns to 0; no pulse at any other index.
- Swap timing:
  - swap_req mid-frame -> swap_pending=1 until the wrap, front_sel toggles there, pixel 0 is read from the new plane.
  - swap_req on the wrap cycle -> toggles only at the next wrap.
- Boundaries:
  - wr_addr=76800 -> no RAM change.
  - pix_next with pix_valid=0 -> index unchanged.
  - pal_wr_en to the entry being looked up in the same cycle -> old colour for that pixel, new colour for the next one.
- Async reset asserted mid-frame with swap_pending=1 -> all outputs return to their reset values without a clock edge, swap_pending=0, front_sel=0.
